seq_alu_n: RTL and testbench

- Parametrised, handshaked successor to the 4-bit combinational ALU slice.
- WIDTH-bit operands. Adds registered results and flags.
- Multi-cycle shift and multiply ops driven by an internal FSM.
- Sits between an operand-issue stage and a result-consume stage. Valid/ready on both sides.

---
 rtl/seq_alu_pkg.sv | 30 +++
 rtl/seq_alu_mul_iter.sv | 72 +++++++
 rtl/seq_alu_n.sv | 216 +++++++++++++++++++++
 tb/tb_seq_alu_n.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode/state encodings and helpers for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_XNOR  = 4'd5,
        OP_PASSA = 4'd6,
        OP_NOTA  = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_MUL   = 4'd10
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for opcodes that may need more than one cycle (shift amount 0 is
    // still resolved in a single cycle by the caller).
    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/seq_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: loaded on start_i, then performs
// exactly WIDTH add/shift steps. last_o flags the cycle whose step is final;
// prod_o shows the accumulator including the current step.
module seq_alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] partial_s;
    logic [2*WIDTH-1:0] acc_step_s;

    assign partial_s  = mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}};
    assign acc_step_s = acc_q + partial_s;
    assign prod_o     = acc_step_s;
    assign last_o     = busy_q && (cnt_q == CW'(1));

    // Next-state: load on start, otherwise one add/shift step per busy cycle.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            acc_d    = {2*WIDTH{1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step_s;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CW'(1);
            busy_d   = (cnt_q != CW'(1));
        end else begin
            busy_d   = 1'b0;
        end
    end

    // Multiplier state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= {2*WIDTH{1'b0}};
            mcand_q  <= {2*WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/seq_alu_n.sv
// Handshaked WIDTH-bit ALU with registered result/flags. Single-cycle logic
// ops complete on the accept edge; shifts iterate one bit per cycle and MUL
// runs on the iterative multiplier.
module seq_alu_n #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry,
    output logic             zero,
    output logic             eq,
    output logic             err
);

    import seq_alu_pkg::*;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               shl_q, shl_d;
    logic               mul_q, mul_d;
    logic               eq_pend_q, eq_pend_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               eq_q, eq_d;
    logic               err_q, err_d;

    logic               accept_s;
    logic               go_busy_s;
    logic [SHW-1:0]     amt_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   sh_step_s;
    logic [WIDTH-1:0]   sc_res_s;
    logic               sc_carry_s;
    logic               sc_err_s;
    logic               mul_start_s;
    logic               mul_last_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    // Ready depends on state and out_ready only, never on in_valid.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign amt_s     = b[SHW-1:0];
    assign go_busy_s = is_multi(op) && ((op == OP_MUL) || (amt_s != {SHW{1'b0}}));
    assign mul_start_s = accept_s && (op == OP_MUL);

    assign sum_s  = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, cin};
    assign diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
    assign sh_step_s = shl_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign eq        = eq_q;
    assign err       = err_q;

    seq_alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start_s),
        .a_i     (a),
        .b_i     (b),
        .last_o  (mul_last_s),
        .prod_o  (mul_prod_s)
    );

    // Result of any op that completes on its accept edge (shift by 0 = pass).
    always_comb begin
        sc_res_s   = {WIDTH{1'b0}};
        sc_carry_s = 1'b0;
        sc_err_s   = 1'b0;
        case (op)
            OP_ADD:   begin
                sc_res_s   = sum_s[WIDTH-1:0];
                sc_carry_s = sum_s[WIDTH];
            end
            OP_SUB:   begin
                sc_res_s   = diff_s[WIDTH-1:0];
                sc_carry_s = diff_s[WIDTH];
            end
            OP_AND:   sc_res_s = a & b;
            OP_OR:    sc_res_s = a | b;
            OP_XOR:   sc_res_s = a ^ b;
            OP_XNOR:  sc_res_s = ~(a ^ b);
            OP_PASSA: sc_res_s = a;
            OP_NOTA:  sc_res_s = ~a;
            OP_SHL,
            OP_SHR:   sc_res_s = a;
            OP_MUL:   sc_res_s = {WIDTH{1'b0}};
            default:  sc_err_s = 1'b1;
        endcase
    end

    // FSM next-state and output-register loading (outputs change only on DONE entry).
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        shl_d     = shl_q;
        mul_d     = mul_q;
        eq_pend_d = eq_pend_q;
        res_d     = res_q;
        res_hi_d  = res_hi_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        eq_d      = eq_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE,
            ST_DONE: begin
                if (accept_s) begin
                    eq_pend_d = (a == b);
                    shl_d     = (op == OP_SHL);
                    mul_d     = (op == OP_MUL);
                    sh_d      = a;
                    cnt_d     = amt_s;
                    if (go_busy_s) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        res_d    = sc_res_s;
                        res_hi_d = {WIDTH{1'b0}};
                        carry_d  = sc_carry_s;
                        zero_d   = (sc_res_s == {WIDTH{1'b0}});
                        eq_d     = (a == b);
                        err_d    = sc_err_s;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BUSY: begin
                if (mul_q) begin
                    if (mul_last_s) begin
                        state_d  = ST_DONE;
                        res_d    = mul_prod_s[WIDTH-1:0];
                        res_hi_d = mul_prod_s[2*WIDTH-1:WIDTH];
                        carry_d  = 1'b0;
                        zero_d   = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        eq_d     = eq_pend_q;
                        err_d    = 1'b0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    sh_d  = sh_step_s;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d  = ST_DONE;
                        res_d    = sh_step_s;
                        res_hi_d = {WIDTH{1'b0}};
                        carry_d  = 1'b0;
                        zero_d   = (sh_step_s == {WIDTH{1'b0}});
                        eq_d     = eq_pend_q;
                        err_d    = 1'b0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sh_q      <= {WIDTH{1'b0}};
            cnt_q     <= {SHW{1'b0}};
            shl_q     <= 1'b0;
            mul_q     <= 1'b0;
            eq_pend_q <= 1'b0;
            res_q     <= {WIDTH{1'b0}};
            res_hi_q  <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            eq_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            shl_q     <= shl_d;
            mul_q     <= mul_d;
            eq_pend_q <= eq_pend_d;
            res_q     <= res_d;
            res_hi_q  <= res_hi_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            eq_q      <= eq_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_alu_n.sv
// Directed scoreboard bench for seq_alu_n (WIDTH=8).
module tb_seq_alu_n;

    import seq_alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] res_hi;
        logic         carry;
        logic         zero;
        logic         eq;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         carry;
    logic         zero;
    logic         eq;
    logic         err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   ov_seen = 1'b0;
    exp_t sb[$];

    seq_alu_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .carry     (carry),
        .zero      (zero),
        .eq        (eq),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model of one operation, including its expected latency.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] aa,
                                   input logic [W-1:0] bb, input logic c);
        exp_t         m;
        logic [W:0]   s;
        logic [W-1:0] nb;
        logic [2*W-1:0] p;
        int           amt;
        m.res_hi = '0;
        m.carry  = 1'b0;
        m.err    = 1'b0;
        m.lat    = 1;
        m.acc    = 0;
        m.eq     = (aa == bb);
        m.res    = '0;
        amt      = int'(bb[2:0]);
        nb       = ~bb;
        case (o)
            OP_ADD:   begin s = aa + bb + c; m.res = s[W-1:0]; m.carry = s[W]; end
            OP_SUB:   begin s = aa + nb + c; m.res = s[W-1:0]; m.carry = s[W]; end
            OP_AND:   m.res = aa & bb;
            OP_OR:    m.res = aa | bb;
            OP_XOR:   m.res = aa ^ bb;
            OP_XNOR:  m.res = ~(aa ^ bb);
            OP_PASSA: m.res = aa;
            OP_NOTA:  m.res = ~aa;
            OP_SHL:   begin m.res = aa << amt; m.lat = 1 + amt; end
            OP_SHR:   begin m.res = aa >> amt; m.lat = 1 + amt; end
            OP_MUL:   begin p = aa * bb; m.res = p[W-1:0]; m.res_hi = p[2*W-1:W]; m.lat = 1 + W; end
            default:  m.err = 1'b1;
        endcase
        m.zero = (m.res == '0);
        return m;
    endfunction

    // Scoreboard: check first appearance (fields + latency), stability while held, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            ov_seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                if (!ov_seen) begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                    chk("res",     {24'd0, res},    {24'd0, sb[0].res});
                    chk("res_hi",  {24'd0, res_hi}, {24'd0, sb[0].res_hi});
                    chk("carry",   {31'd0, carry},  {31'd0, sb[0].carry});
                    chk("zero",    {31'd0, zero},   {31'd0, sb[0].zero});
                    chk("eq",      {31'd0, eq},     {31'd0, sb[0].eq});
                    chk("err",     {31'd0, err},    {31'd0, sb[0].err});
                    ov_seen = 1'b1;
                end else begin
                    chk("hold_stable", {12'd0, res_hi, res, carry, zero, eq, err},
                        {12'd0, sb[0].res_hi, sb[0].res, sb[0].carry, sb[0].zero, sb[0].eq, sb[0].err});
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    ov_seen = 1'b0;
                end
            end
        end
    end

    // Present one op (called just after a rising edge), wait for acceptance, queue expectation.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic c);
        exp_t e;
        int   n;
        op = o; a = aa; b = bb; cin = c; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        e = model(o, aa, bb, c);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued result has been consumed.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; a = '0; b = '0; cin = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {12'd0, res_hi, res, carry, zero, eq, err}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // ADD with carry, in_ready high in the DONE cycle
        issue(OP_ADD, 8'hF0, 8'h20, 1'b1);
        @(negedge clk);
        chk("add_res_const", {24'd0, res}, 32'h11);
        chk("add_in_ready_done", {31'd0, in_ready}, 32'd1);
        drain();

        // SUB equal operands, then borrow
        issue(OP_SUB, 8'h55, 8'h55, 1'b1);
        drain();
        issue(OP_SUB, 8'h00, 8'h01, 1'b1);
        drain();

        // MUL 0xFF*0xFF, in_valid during BUSY ignored
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0);
        op = OP_ADD; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready", {31'd0, in_ready}, 32'd0);
            chk("mul_busy_out_valid", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_res_hi_const", {24'd0, res_hi}, 32'hFE);
        drain();

        // Shifts: multi-cycle, zero amount, upper amount bits ignored
        issue(OP_SHL, 8'h81, 8'h03, 1'b0);
        drain();
        issue(OP_SHR, 8'h81, 8'h00, 1'b0);
        drain();
        issue(OP_SHR, 8'h81, 8'hF9, 1'b0);
        drain();

        // Backpressure, then back-to-back accept on release
        out_ready = 1'b0;
        issue(OP_ADD, 8'h3C, 8'h41, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        issue(OP_XOR, 8'h0F, 8'hFF, 1'b0);
        drain();

        // Illegal opcode and a plain logic op
        issue(4'hC, 8'h12, 8'h12, 1'b1);
        drain();
        issue(OP_OR, 8'h0F, 8'h30, 1'b0);
        drain();

        // Reset during BUSY cycle 4 of a MUL
        issue(OP_MUL, 8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_res", {24'd0, res}, 32'd0);
        chk("midrst_res_hi", {24'd0, res_hi}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Operation after reset recovery
        issue(OP_XNOR, 8'h3C, 8'h0F, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
